// File: rtl/npc_bpred.sv
// Next-PC generator: owns the fetch PC, predicts via a direct-mapped BTB with 2-bit counters,
// redirects and flushes on EX misprediction. Define NPC_BPRED_STATS_EN to add br_cnt/mispred_cnt.
module npc_bpred #(
  parameter int unsigned     XLEN     = 32,
  parameter int unsigned     IDX_BITS = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            halt,
  input  logic            stall,
  output logic [XLEN-1:0] pc,
  output logic            pred_taken,
  output logic [XLEN-1:0] pred_target,
  input  logic            res_valid,
  input  logic [XLEN-1:0] res_pc,
  input  logic            res_branch,
  input  logic            res_jump,
  input  logic            res_taken,
  input  logic [XLEN-1:0] res_target,
  input  logic            res_pred_taken,
  input  logic [XLEN-1:0] res_pred_target,
  output logic            flush
`ifdef NPC_BPRED_STATS_EN
  ,
  output logic [31:0]     br_cnt,
  output logic [31:0]     mispred_cnt
`endif
);

  localparam int unsigned DEPTH = 1 << IDX_BITS;
  localparam int unsigned TAG_W = XLEN - IDX_BITS;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    logic [1:0]       ctr;
  } btb_entry_t;

  btb_entry_t btb [DEPTH];

  logic [IDX_BITS-1:0] lk_idx;
  btb_entry_t          lk_e;
  logic                lk_hit;
  logic [IDX_BITS-1:0] rs_idx;
  logic [TAG_W-1:0]    rs_tag;
  btb_entry_t          rs_e;
  logic                rs_hit;
  logic                upd;
  logic                act_taken;
  logic [XLEN-1:0]     act_next;
  logic                mispredict;

  // Fetch-side lookup sees pre-update contents; no write bypass.
  always_comb begin
    lk_idx      = pc[IDX_BITS-1:0];
    lk_e        = btb[lk_idx];
    lk_hit      = lk_e.valid && (lk_e.tag == pc[XLEN-1:IDX_BITS]);
    pred_taken  = lk_hit && lk_e.ctr[1];
    pred_target = pred_taken ? lk_e.target : pc + XLEN'(1);
  end

  // Resolution side: actual outcome and misprediction detect.
  always_comb begin
    rs_idx     = res_pc[IDX_BITS-1:0];
    rs_tag     = res_pc[XLEN-1:IDX_BITS];
    rs_e       = btb[rs_idx];
    rs_hit     = rs_e.valid && (rs_e.tag == rs_tag);
    upd        = res_valid && (res_branch || res_jump);
    act_taken  = res_jump || res_taken;
    act_next   = act_taken ? res_target : res_pc + XLEN'(1);
    mispredict = upd && ((act_taken != res_pred_taken) || (act_next != res_pred_target));
    flush      = mispredict;
  end

  // Redirect beats stall; halt beats everything but reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc <= RESET_PC;
    end else if (!halt) begin
      if (mispredict)  pc <= act_next;
      else if (!stall) pc <= pred_target;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        btb[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: 2'b01};
      end
    end else if (upd) begin
      if (res_jump) begin
        btb[rs_idx] <= '{valid: 1'b1, tag: rs_tag, target: res_target, ctr: 2'b11};
      end else if (res_taken) begin
        if (rs_hit) begin
          btb[rs_idx].ctr    <= (rs_e.ctr == 2'b11) ? 2'b11 : rs_e.ctr + 2'd1;
          btb[rs_idx].target <= res_target;
        end else begin
          btb[rs_idx] <= '{valid: 1'b1, tag: rs_tag, target: res_target, ctr: 2'b10};
        end
      end else if (rs_hit) begin
        btb[rs_idx].ctr <= (rs_e.ctr == 2'b00) ? 2'b00 : rs_e.ctr - 2'd1;
      end
    end
  end

`ifdef NPC_BPRED_STATS_EN
  // Saturating event counters, independent of halt/stall.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      br_cnt      <= '0;
      mispred_cnt <= '0;
    end else begin
      if (upd && (br_cnt != 32'hFFFF_FFFF))             br_cnt      <= br_cnt + 32'd1;
      if (mispredict && (mispred_cnt != 32'hFFFF_FFFF)) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
`endif

endmodule
